seg7_scan_scheduler: RTL and testbench
======================================

Name: seg7_scan_scheduler

Overview:
Time-multiplexes one shared 7-segment decoder across the four digits of the board display, replacing the fixed single-digit enable pattern 4'b1110.
- Accepts a 16-bit hex value plus per-digit decimal-point and blank masks through a valid/ready load port, typically driven by the adder datapath.
- Scans digits 0..3 round-robin, driving active-low segment, decimal-point and digit-enable lines.
- Applies new values only at frame boundaries, so the display never shows a half-updated value.

Parameters:
- DIV_MAX, 100000: clock cycles each digit stays lit, including the dead cycle (100 MHz gives about 1 kHz per digit); legal range 2 or more.
- NUM_DIGITS, 4: digits scanned; fixed at 4 in this revision.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- load_valid  in  1  requester presents new display data
- load_ready  out  1  scheduler can accept data
- load_value  in  16  four hex nibbles; digit0 = [3:0] ... digit3 = [15:12]
- load_dp  in  4  decimal point per digit, 1 = lit
- load_blank  in  4  per-digit blank, 1 = digit dark
- Port  out  7  segments a..g, active low
- Dp  out  1  decimal point, active low
- control  out  4  digit enables, active low, bit i = digit i
- frame_done  out  1  one-cycle pulse when digit 3's slot ends

Behaviour:
- Reset, asynchronous:
  - control = 4'b1111, Port = 7'b1111111, Dp = 1, frame_done = 0, load_ready = 1.
  - Display registers and shadow registers are cleared to all digits blank.
  - Divider = 0, digit index = 0.
- Divider counts 0..DIV_MAX-1, then wraps to 0 and advances the digit index 0→1→2→3→0.
- Dead cycle: while the divider is 0, control = 4'b1111 (anti-ghosting). For divider values 1..DIV_MAX-1, control has the current digit's bit cleared, unless that digit is blanked, in which case control = 4'b1111.
- Port and Dp are registered and update on the same edge as control.
  - Port = decode(nibble), using standard hex glyphs 0-F.
  - Dp = ~dp[idx].
  - A blanked digit forces Port = 7'h7F and Dp = 1.
- Load handshake:
  - A transfer occurs on a clk edge with load_valid && load_ready.
  - Data goes into the shadow registers; a pending flag is set and load_ready drops to 0 on the next cycle.
  - At the wrap from digit 3 to digit 0, shadow copies into the display registers, pending clears and load_ready returns to 1 on the following cycle.
  - frame_done pulses in that same wrap cycle.
- If a load transfer and the frame wrap happen in the same cycle, the old shadow is committed. The new data stays pending until the next wrap (no bypass).
- load_valid while load_ready = 0 is ignored; the requester must hold its data until ready.
- Reset mid-frame: outputs go immediately to their reset values and any pending shadow data is discarded.
- No combinational path from inputs to outputs; load_ready is a register.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined: at commit, digits 3, 2 and 1 are additionally blanked when they and every higher digit hold zero and their load_blank bit is clear. Digit 0 is never auto-blanked, so 0x0000 shows "0" and 0x00A0 shows "A0". Auto-blank also suppresses the decimal point of that digit.
- Undefined: only load_blank controls blanking.

Decomposition:
- Package seg7_pkg:
  - localparams for the 16 active-low glyph codes.
  - SEG_OFF = 7'h7F, DIG_OFF = 4'hF.
  - Digit-index width constant.
- Sub-module seg7_hex_decoder: combinational nibble → active-low 7-bit code, instantiated once as the shared decoder.

Test Plan:
1. Reset with DIV_MAX = 4, no load → control = 4'hF, Port = 7'h7F, Dp = 1, load_ready = 1 on every cycle; frame_done pulses every 16 cycles.
2. Load 16'h1234, dp = 4'b0010, blank = 0 → after the next wrap, each 4-cycle slot shows 1 dead cycle (control = F) then 3 cycles of: digit0 control = 1110, Port = code(4); digit1 control = 1101, code(3), Dp = 0; digit2 control = 1011, code(2); digit3 control = 0111, code(1).
3. Hold load_valid with 16'hAAAA then 16'h5555 back-to-back → the second value is not accepted until load_ready returns after frame_done; the display shows AAAA for one full frame, then 5555.
4. Issue load in the exact wrap cycle → the previous shadow commits; the new value appears one frame later.
5. Assert rst_n = 0 mid-digit-2 slot → outputs return to their reset values asynchronously before the next clk edge; the pending load is lost.
6. With SEG7_LEADING_ZERO_BLANK_EN, load 16'h0070 → digits 3 and 2 stay control = F, digit1 shows 7, digit0 shows 0; load 16'h0000 → only digit0 lit, showing 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan scheduler: active-low glyphs, blank codes, index width.
// The leading-zero helper is used only when SEG7_LEADING_ZERO_BLANK_EN is defined.
package seg7_pkg;

  localparam int IDX_W = 2;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] DIG_OFF = 4'hF;

  // Bit order is {g,f,e,d,c,b,a}; a cleared bit lights the segment.
  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  // Digits 3..1 go dark while they and all higher digits are zero; digit 0 always stays lit.
  function automatic logic [3:0] leadingZeroBlank(input logic [15:0] value,
                                                  input logic [3:0]  blank);
    logic [3:0] result;
    logic       allZero;
    result  = blank;
    allZero = 1'b1;
    for (int d = 3; d >= 1; d--) begin
      allZero   = allZero && (value[4*d +: 4] == 4'h0);
      result[d] = result[d] | allZero;
    end
    return result;
  endfunction

endpackage

// File: rtl/seg7_scan_scheduler_decoder.sv
// Shared combinational hex-to-segment decoder (nibble to active-low glyph).
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    case (nibble_i)
      4'h0: seg_o = GLYPH_0;
      4'h1: seg_o = GLYPH_1;
      4'h2: seg_o = GLYPH_2;
      4'h3: seg_o = GLYPH_3;
      4'h4: seg_o = GLYPH_4;
      4'h5: seg_o = GLYPH_5;
      4'h6: seg_o = GLYPH_6;
      4'h7: seg_o = GLYPH_7;
      4'h8: seg_o = GLYPH_8;
      4'h9: seg_o = GLYPH_9;
      4'hA: seg_o = GLYPH_A;
      4'hB: seg_o = GLYPH_B;
      4'hC: seg_o = GLYPH_C;
      4'hD: seg_o = GLYPH_D;
      4'hE: seg_o = GLYPH_E;
      4'hF: seg_o = GLYPH_F;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_scheduler.sv
// Round-robin four-digit scan with frame-aligned display updates through a valid/ready load port.
// Define SEG7_LEADING_ZERO_BLANK_EN to auto-blank leading zero digits at commit.
module seg7_scan_scheduler
  import seg7_pkg::*;
#(
  parameter int DIV_MAX    = 100000,
  parameter int NUM_DIGITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_value,
  input  logic [3:0]  load_dp,
  input  logic [3:0]  load_blank,
  output logic [6:0]  Port,
  output logic        Dp,
  output logic [3:0]  control,
  output logic        frame_done
);

  localparam int DIVW = (DIV_MAX > 2) ? $clog2(DIV_MAX) : 1;
  localparam logic [DIVW-1:0]  DIV_LAST = DIVW'(DIV_MAX - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [DIVW-1:0]  div_q, div_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      shadowValue_q, shadowValue_d, dispValue_q, dispValue_d;
  logic [3:0]       shadowDp_q, shadowDp_d, dispDp_q, dispDp_d;
  logic [3:0]       shadowBlank_q, shadowBlank_d, dispBlank_q, dispBlank_d;
  logic             pending_q, pending_d;
  logic             ready_q;
  logic [6:0]       port_q, port_d;
  logic             dp_q, dp_d;
  logic [3:0]       control_q, control_d;
  logic             frameDone_q, frameDone_d;
  logic [3:0]       commitBlank;
  logic [3:0]       nibble;
  logic [6:0]       glyph;
  logic             lastCycle, wrap, xfer, digBlank;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  assign commitBlank = leadingZeroBlank(shadowValue_q, shadowBlank_q);
`else
  assign commitBlank = shadowBlank_q;
`endif

  seg7_hex_decoder uDecoder (
    .nibble_i (nibble),
    .seg_o    (glyph)
  );

  // Outputs are computed from next-state so they change on the same edge as the scan position.
  always_comb begin
    lastCycle = (div_q == DIV_LAST);
    wrap      = lastCycle && (idx_q == IDX_LAST);
    xfer      = load_valid && ready_q;
    div_d     = lastCycle ? '0 : div_q + DIVW'(1);
    idx_d     = lastCycle ? idx_q + IDX_W'(1) : idx_q;

    shadowValue_d = xfer ? load_value : shadowValue_q;
    shadowDp_d    = xfer ? load_dp    : shadowDp_q;
    shadowBlank_d = xfer ? load_blank : shadowBlank_q;
    pending_d     = xfer || (pending_q && !wrap);

    dispValue_d = dispValue_q;
    dispDp_d    = dispDp_q;
    dispBlank_d = dispBlank_q;
    if (wrap && pending_q) begin
      dispValue_d = shadowValue_q;
      dispDp_d    = shadowDp_q;
      dispBlank_d = commitBlank;
    end

    nibble   = dispValue_d[{idx_d, 2'b00} +: 4];
    digBlank = dispBlank_d[idx_d];

    control_d = DIG_OFF;
    if ((div_d != '0) && !digBlank) begin
      control_d[idx_d] = 1'b0;
    end
    port_d      = digBlank ? SEG_OFF : glyph;
    dp_d        = digBlank ? 1'b1 : ~dispDp_d[idx_d];
    frameDone_d = (div_d == DIV_LAST) && (idx_d == IDX_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      idx_q         <= '0;
      shadowValue_q <= '0;
      shadowDp_q    <= '0;
      shadowBlank_q <= 4'hF;
      dispValue_q   <= '0;
      dispDp_q      <= '0;
      dispBlank_q   <= 4'hF;
      pending_q     <= 1'b0;
      ready_q       <= 1'b1;
      port_q        <= SEG_OFF;
      dp_q          <= 1'b1;
      control_q     <= DIG_OFF;
      frameDone_q   <= 1'b0;
    end else begin
      div_q         <= div_d;
      idx_q         <= idx_d;
      shadowValue_q <= shadowValue_d;
      shadowDp_q    <= shadowDp_d;
      shadowBlank_q <= shadowBlank_d;
      dispValue_q   <= dispValue_d;
      dispDp_q      <= dispDp_d;
      dispBlank_q   <= dispBlank_d;
      pending_q     <= pending_d;
      ready_q       <= ~pending_d;
      port_q        <= port_d;
      dp_q          <= dp_d;
      control_q     <= control_d;
      frameDone_q   <= frameDone_d;
    end
  end

  assign load_ready = ready_q;
  assign Port       = port_q;
  assign Dp         = dp_q;
  assign control    = control_q;
  assign frame_done = frameDone_q;

endmodule

// File: tb/tb_seg7_scan_scheduler.sv
// Randomized self-checking bench for seg7_scan_scheduler against a frame-arithmetic reference model.
module tb_seg7_scan_scheduler;

  localparam int D     = 4;
  localparam int FRAME = 4 * D;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_value = '0;
  logic [3:0]  load_dp = '0;
  logic [3:0]  load_blank = '0;
  logic [6:0]  Port;
  logic        Dp;
  logic [3:0]  control;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  // Reference model: n counts clock edges since reset; digit and divider follow from plain arithmetic.
  int          n;
  logic [15:0] mVal, sVal;
  logic [3:0]  mDp, mBlank, sDp, sBlank;
  bit          mPend;

  // Active-high segment patterns {g..a} for 0..F; the display drives their inverse.
  logic [6:0] segOn [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always #5 clk = ~clk;

  seg7_scan_scheduler #(.DIV_MAX(D), .NUM_DIGITS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .load_dp    (load_dp),
    .load_blank (load_blank),
    .Port       (Port),
    .Dp         (Dp),
    .control    (control),
    .frame_done (frame_done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s at n=%0d observed=%0h expected=%0h", tag, n, observed, expected);
    end
  endtask

  function automatic logic [3:0] committedBlank(input logic [15:0] v, input logic [3:0] b);
    logic [3:0] r;
    r = b;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (v[15:12] == 0)                   r[3] = 1'b1;
    if (v[15:8]  == 0)                   r[2] = 1'b1;
    if (v[15:4]  == 0)                   r[1] = 1'b1;
`endif
    return r;
  endfunction

  task automatic modelReset();
    n = 0; mPend = 0;
    mVal = '0; mDp = '0; mBlank = 4'hF;
    sVal = '0; sDp = '0; sBlank = 4'hF;
  endtask

  task automatic checkAll();
    int         idx, dv;
    logic [3:0] nib, expCtrl;
    logic       blk;
    idx = (n / D) % 4;
    dv  = n % D;
    nib = mVal[idx*4 +: 4];
    blk = mBlank[idx];
    expCtrl = 4'hF;
    if (dv != 0 && !blk) expCtrl = ~(4'b0001 << idx);
    checkOutput("control", {28'd0, control}, {28'd0, expCtrl});
    checkOutput("Port", {25'd0, Port}, blk ? 32'h7F : {25'd0, ~segOn[nib]});
    checkOutput("Dp", {31'd0, Dp}, blk ? 32'd1 : {31'd0, ~mDp[idx]});
    checkOutput("frame_done", {31'd0, frame_done}, {31'd0, ((n % FRAME) == FRAME - 1)});
    checkOutput("load_ready", {31'd0, load_ready}, {31'd0, !mPend});
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] val, input logic [3:0] dp, input logic [3:0] blank);
    load_valid = v;
    load_value = val;
    load_dp    = dp;
    load_blank = blank;
  endtask

  task automatic stepCycle();
    bit wrap, xfer;
    @(posedge clk);
    wrap = (n % FRAME) == FRAME - 1;
    xfer = load_valid && !mPend;
    if (wrap && mPend) begin
      mVal = sVal; mDp = sDp; mBlank = committedBlank(sVal, sBlank);
    end
    mPend = xfer || (mPend && !wrap);
    if (xfer) begin
      sVal = load_value; sDp = load_dp; sBlank = load_blank;
    end
    n++;
    @(negedge clk);
    checkAll();
  endtask

  // Requester holds its data until the model says it was taken.
  task automatic loadHeld(input logic [15:0] val, input logic [3:0] dp, input logic [3:0] blank);
    bit taken;
    applyStimulus(1'b1, val, dp, blank);
    for (int i = 0; i < 3 * FRAME; i++) begin
      taken = !mPend;
      stepCycle();
      if (taken) break;
    end
    applyStimulus(1'b0, val, dp, blank);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) stepCycle();
  endtask

  initial begin
    bit          holding, taken;
    logic [15:0] rv;
    modelReset();
    #1 rst_n = 1'b0;
    #1 checkAll();
    @(negedge clk);
    checkAll();
    rst_n = 1'b1;

    idle(2 * FRAME);

    loadHeld(16'h1234, 4'b0010, 4'b0000);
    idle(2 * FRAME);

    loadHeld(16'hAAAA, 4'b0000, 4'b0000);
    loadHeld(16'h5555, 4'b1111, 4'b0000);
    idle(3 * FRAME);

    for (int i = 0; i < 2 * FRAME; i++) begin
      if (!mPend && (n % FRAME) == FRAME - 1) break;
      stepCycle();
    end
    applyStimulus(1'b1, 16'hBEEF, 4'b0101, 4'b0000);
    stepCycle();
    applyStimulus(1'b0, 16'hBEEF, 4'b0101, 4'b0000);
    idle(2 * FRAME);

    loadHeld(16'hC0DE, 4'b1000, 4'b0100);
    idle(2 * FRAME);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if ((n % FRAME) == 0) break;
      stepCycle();
    end
    loadHeld(16'h9876, 4'b0001, 4'b0000);
    for (int i = 0; i < FRAME; i++) begin
      if (((n / D) % 4) == 2 && (n % D) == 2) break;
      stepCycle();
    end
    #2 rst_n = 1'b0;
    modelReset();
    #1 checkAll();
    @(negedge clk);
    checkAll();
    rst_n = 1'b1;
    idle(2 * FRAME);

    loadHeld(16'h0070, 4'b0110, 4'b0000);
    idle(2 * FRAME);
    loadHeld(16'h0000, 4'b0001, 4'b0000);
    idle(2 * FRAME);

    holding = 0;
    for (int i = 0; i < 600; i++) begin
      if (!holding && ($urandom % 4) == 0) begin
        rv = 16'($urandom);
        for (int d = 0; d < 4; d++) if (($urandom % 3) == 0) rv[d*4 +: 4] = 4'h0;
        applyStimulus(1'b1, rv, 4'($urandom), 4'($urandom) & 4'($urandom) & 4'($urandom));
        holding = 1;
      end
      taken = holding && !mPend;
      stepCycle();
      if (taken) begin
        holding = 0;
        load_valid = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
